laser_frame_ctrl: RTL and testbench
===================================

Name: laser_frame_ctrl

Overview:
Frame controller between the laser UART byte receiver and the 8-digit seven-segment display. It consumes the receiver's valid/ready byte stream and parses framed packets: SOF, LEN, payload and XOR checksum. It double-buffers the payload, and commits it to the display bank only when the frame validates. It also time-multiplexes the display bank onto the shared segment/digit lines.

Parameters:
N_DIGITS, 8, number of display digits and maximum payload length
SOF, 8'hA5, start-of-frame byte
TIMEOUT_CYC, 1000000, max clk cycles between accepted bytes inside a frame (20 ms at 50 MHz)
SCAN_DIV, 50000, clk cycles per displayed digit during scan

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
i_tvalid  in  1  byte valid from UART receiver
i_tdata  in  8  received byte
o_tready  out  1  controller can accept byte
o_abcdefgh  out  8  segment pattern of currently scanned digit
o_digit  out  N_DIGITS  one-hot active-high digit select
o_frame_ok  out  1  one-cycle pulse on successful commit
o_frame_err  out  1  one-cycle pulse on any frame error
o_err_cnt  out  8  saturating frame-error count
o_busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rstn; all registers update only on posedge clk.
- Reset values: state=IDLE, o_tready=1, staging and display banks all 8'h00, o_abcdefgh=8'h00, o_digit=1 (index 0), o_frame_ok=0, o_frame_err=0, o_err_cnt=0, o_busy=0, timeout and scan counters 0.
- Handshake: a byte is accepted on a cycle with i_tvalid && o_tready.
  - o_tready=1 in every state except COMMIT.
  - Bytes presented during COMMIT are not consumed; the source holds them.
- FSM states:
  - IDLE: an accepted byte == SOF moves to LEN. Any other byte is discarded silently, with no error.
  - LEN: an accepted byte L with 1 <= L <= N_DIGITS stores len=L, sets chk=L, clears idx=0, and moves to DATA. L=0 or L>N_DIGITS raises an error and returns to IDLE.
  - DATA: an accepted byte B does staging[idx]<=B, chk<=chk^B, idx<=idx+1. After the len-th byte, go to CHK.
    - A byte equal to SOF is treated as ordinary data; there is no resync.
  - CHK: if the accepted byte == chk, go to COMMIT; otherwise raise an error and go to IDLE.
  - COMMIT (exactly 1 cycle):
    - display[i] <= staging[i] for i < len; display[i] <= 8'h00 for i >= len.
    - o_frame_ok pulses in this cycle, then the FSM returns to IDLE.
- Timeout: the counter clears on every accepted byte and while in IDLE, and increments in LEN/DATA/CHK. When it reaches TIMEOUT_CYC-1, an error is raised and the FSM goes to IDLE. The staging bank is left unchanged, and the display bank is untouched.
- Error: o_frame_err pulses for one cycle, registered with the transition. o_err_cnt increments and saturates at 8'hFF.
  - Byte accepted on the same cycle as timeout expiry: the timeout wins and the byte is dropped.
- Display bank: changes only in COMMIT; errors never alter it.
- Scan: the divider counts 0..SCAN_DIV-1. On wrap, the digit index advances (N_DIGITS-1 wraps to 0).
  - o_digit = 1 << index; o_abcdefgh = display[index], combinational from registers.
  - Scan runs independently of the FSM. A COMMIT is visible on the next cycle for whichever digit is currently scanned.
- Reset mid-frame: takes effect on the next posedge. The partial frame is lost, the display clears to 0, and o_err_cnt is cleared.

Test Plan:
- Good frame A5 03 8E CE BC FF (chk 03^8E^CE^BC=FF) -> one o_frame_ok pulse, display = {8E,CE,BC,00,00,00,00,00}. With scan index 1, o_digit=8'b00000010 and o_abcdefgh=8'hCE.
- Same frame with last byte 00 -> one o_frame_err pulse, o_err_cnt=1, display unchanged from prior contents.
- Bytes 11 22 then A5 00 -> no error for 11/22. LEN=0 gives o_frame_err, err_cnt=1, and the FSM returns to IDLE, with o_busy dropping the cycle after.
- With TIMEOUT_CYC=100: send A5 02 8E, then idle -> o_frame_err exactly 100 cycles after 8E is accepted. A subsequent good frame A5 01 EE EF commits display[0]=EE, rest 00.
- i_tvalid held high continuously with the next frame's SOF immediately after the checksum -> o_tready=0 for exactly one cycle (COMMIT), SOF accepted the following cycle, both frames commit.
- 256 bad frames -> o_err_cnt saturates at FF. rstn=0 for 1 cycle mid-DATA -> err_cnt=0, display zero, o_digit=1, state IDLE.

Source files
------------

// File: rtl/laser_frame_ctrl.sv
// Framed-packet parser (SOF, LEN, payload, XOR checksum) feeding a double-buffered
// seven-segment display bank, plus the digit scan multiplexer.
module laser_frame_ctrl #(
  parameter int         N_DIGITS    = 8,
  parameter logic [7:0] SOF         = 8'hA5,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter int         SCAN_DIV    = 50000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_tvalid,
  input  logic [7:0]          i_tdata,
  output logic                o_tready,
  output logic [7:0]          o_abcdefgh,
  output logic [N_DIGITS-1:0] o_digit,
  output logic                o_frame_ok,
  output logic                o_frame_err,
  output logic [7:0]          o_err_cnt,
  output logic                o_busy
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int LW = $clog2(N_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_COMMIT} state_t;

  state_t                     state, state_nxt;
  logic [LW-1:0]              len_q, idx_q;
  logic [7:0]                 chk_q;
  logic [N_DIGITS-1:0][7:0]   staging_q, display_q;
  logic [TW-1:0]              tmo_q;
  logic                       err_q, err_set;
  logic [7:0]                 err_cnt_q;
  logic [SW-1:0]              scan_cnt_q;
  logic [IW-1:0]              scan_idx_q;
  logic                       accept, tmo_hit, take, len_ok;

  assign accept  = i_tvalid && o_tready;
  assign tmo_hit = (state == S_LEN || state == S_DATA || state == S_CHK) &&
                   (tmo_q == TW'(TIMEOUT_CYC - 1));
  // Timeout expiry beats a byte arriving in the same cycle; that byte is dropped.
  assign take    = accept && !tmo_hit;
  assign len_ok  = (i_tdata != 8'h00) && (i_tdata <= 8'(N_DIGITS));

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    if (tmo_hit) begin
      state_nxt = S_IDLE;
      err_set   = 1'b1;
    end else begin
      case (state)
        S_IDLE:   if (take && i_tdata == SOF) state_nxt = S_LEN;
        S_LEN:    if (take) begin
                    state_nxt = len_ok ? S_DATA : S_IDLE;
                    err_set   = !len_ok;
                  end
        S_DATA:   if (take && idx_q == len_q - LW'(1)) state_nxt = S_CHK;
        S_CHK:    if (take) begin
                    state_nxt = (i_tdata == chk_q) ? S_COMMIT : S_IDLE;
                    err_set   = (i_tdata != chk_q);
                  end
        S_COMMIT: state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      chk_q      <= '0;
      staging_q  <= '0;
      display_q  <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
    end else begin
      state <= state_nxt;
      err_q <= err_set;
      if (err_set && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;

      if (state == S_IDLE || state == S_COMMIT || accept) tmo_q <= '0;
      else                                                tmo_q <= tmo_q + TW'(1);

      case (state)
        S_LEN: if (take && len_ok) begin
          len_q <= LW'(i_tdata);
          chk_q <= i_tdata;
          idx_q <= '0;
        end
        S_DATA: if (take) begin
          staging_q[idx_q[IW-1:0]] <= i_tdata;
          chk_q                    <= chk_q ^ i_tdata;
          idx_q                    <= idx_q + LW'(1);
        end
        // Digits beyond this frame's length are blanked, not left stale.
        S_COMMIT: for (int i = 0; i < N_DIGITS; i++)
          display_q[i] <= (i < int'(len_q)) ? staging_q[i] : 8'h00;
        default: ;
      endcase

      if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
        scan_cnt_q <= '0;
        scan_idx_q <= (scan_idx_q == IW'(N_DIGITS - 1)) ? '0 : scan_idx_q + IW'(1);
      end else begin
        scan_cnt_q <= scan_cnt_q + SW'(1);
      end
    end
  end

  assign o_tready    = (state != S_COMMIT);
  assign o_busy      = (state != S_IDLE);
  assign o_frame_ok  = (state == S_COMMIT);
  assign o_frame_err = err_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_digit     = N_DIGITS'(1) << scan_idx_q;
  assign o_abcdefgh  = display_q[scan_idx_q];

endmodule

// File: tb/tb_laser_frame_ctrl.sv
// Self-checking bench for laser_frame_ctrl: directed frame table, multi-cycle corner
// sequences and random frames checked against a frame-level model.
module tb_laser_frame_ctrl;
  localparam int N   = 8;
  localparam int TMO = 100;
  localparam int SD  = 3;

  logic         clk = 1'b0, rstn = 1'b0, i_tvalid = 1'b0;
  logic [7:0]   i_tdata = 8'h00;
  logic         o_tready, o_frame_ok, o_frame_err, o_busy;
  logic [7:0]   o_abcdefgh, o_err_cnt;
  logic [N-1:0] o_digit;

  laser_frame_ctrl #(.N_DIGITS(N), .SOF(8'hA5), .TIMEOUT_CYC(TMO), .SCAN_DIV(SD)) dut (
    .clk(clk), .rstn(rstn), .i_tvalid(i_tvalid), .i_tdata(i_tdata), .o_tready(o_tready),
    .o_abcdefgh(o_abcdefgh), .o_digit(o_digit), .o_frame_ok(o_frame_ok),
    .o_frame_err(o_frame_err), .o_err_cnt(o_err_cnt), .o_busy(o_busy));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int ok_seen = 0, err_seen = 0, cyc = 0;
  logic [7:0] model_disp [N];
  int model_cnt = 0;

  always @(posedge clk) cyc <= rstn ? cyc + 1 : 0;
  always @(negedge clk) begin
    if (o_frame_ok)  ok_seen  <= ok_seen + 1;
    if (o_frame_err) err_seen <= err_seen + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: outcome of one frame (optional non-SOF garbage first);
  // a frame that stops short is expected to time out.
  function automatic void model(input logic [7:0] q[$], output bit ok, output bit err);
    int i = 0;
    int L;
    logic [7:0] x;
    ok = 0; err = 0;
    while (i < q.size() && q[i] != 8'hA5) i++;
    if (i >= q.size()) return;
    if (i + 1 >= q.size()) err = 1;
    else begin
      L = int'(q[i+1]);
      if (L == 0 || L > N || i + 2 + L >= q.size()) err = 1;
      else begin
        x = q[i+1];
        for (int j = 0; j < L; j++) x ^= q[i+2+j];
        if (x == q[i+2+L]) begin
          ok = 1;
          for (int k = 0; k < N; k++) model_disp[k] = (k < L) ? q[i+2+k] : 8'h00;
        end else err = 1;
      end
    end
    if (err && model_cnt < 255) model_cnt++;
  endfunction

  task automatic send_byte(input logic [7:0] b, output int w);
    w = 0;
    i_tvalid = 1'b1;
    i_tdata  = b;
    while (!o_tready && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (w >= 10) check("tready_stuck", 32'd0, 32'd1);
    @(negedge clk);
    i_tvalid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] q[$], input int maxgap);
    int w;
    foreach (q[i]) begin
      send_byte(q[i], w);
      if (i != q.size() - 1 && maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
    end
  endtask

  task automatic check_display();
    int idx;
    repeat (N * SD) begin
      @(negedge clk);
      idx = (cyc / SD) % N;
      check("digit_sel", 32'(o_digit), 32'(1) << idx);
      check("segments", 32'(o_abcdefgh), 32'(model_disp[idx]));
    end
  endtask

  task automatic run_frame(input logic [7:0] q[$], input int maxgap, input int settle);
    bit eok, eerr;
    int ok0, er0;
    ok0 = ok_seen; er0 = err_seen;
    model(q, eok, eerr);
    send_seq(q, maxgap);
    repeat (settle) @(negedge clk);
    check("ok_pulses", ok_seen - ok0, 32'(eok));
    check("err_pulses", err_seen - er0, 32'(eerr));
    check("err_cnt", 32'(o_err_cnt), model_cnt);
  endtask

  typedef struct {
    logic [0:11][7:0] b;
    int               n;
    bit               ok;
    bit               err;
    logic [7:0]       cnt;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] q[$], input bit ok, input bit err,
                              input logic [7:0] cnt);
    vec_t v;
    v.b = '0;
    v.n = q.size();
    foreach (q[i]) v.b[i] = q[i];
    v.ok = ok; v.err = err; v.cnt = cnt;
    return v;
  endfunction

  vec_t tbl [6];

  initial begin
    logic [7:0] q[$];
    bit eok, eerr;
    int ok0, er0, w, k, t, L, settle;
    logic [7:0] x;

    foreach (model_disp[i]) model_disp[i] = 8'h00;
    q = {8'hA5, 8'h03, 8'h8E, 8'hCE, 8'hBC, 8'hFF};                 tbl[0] = mk(q, 1, 0, 8'd0);
    q = {8'hA5, 8'h03, 8'h8E, 8'hCE, 8'hBC, 8'h00};                 tbl[1] = mk(q, 0, 1, 8'd1);
    q = {8'h11, 8'h22, 8'hA5, 8'h00};                               tbl[2] = mk(q, 0, 1, 8'd2);
    q = {8'hA5, 8'h09};                                             tbl[3] = mk(q, 0, 1, 8'd3);
    q = {8'hA5, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
         8'h07, 8'hA5, 8'hAD};                                      tbl[4] = mk(q, 1, 0, 8'd3);
    q = {8'hA5, 8'h01, 8'hEE, 8'hEF};                               tbl[5] = mk(q, 1, 0, 8'd3);

    repeat (3) @(negedge clk);
    check("rst_tready", 32'(o_tready), 32'd1);
    check("rst_seg", 32'(o_abcdefgh), 32'd0);
    check("rst_digit", 32'(o_digit), 32'd1);
    check("rst_ok", 32'(o_frame_ok), 32'd0);
    check("rst_err", 32'(o_frame_err), 32'd0);
    check("rst_cnt", 32'(o_err_cnt), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    rstn = 1'b1;

    for (int v = 0; v < 6; v++) begin
      q.delete();
      for (int i = 0; i < tbl[v].n; i++) q.push_back(tbl[v].b[i]);
      ok0 = ok_seen; er0 = err_seen;
      model(q, eok, eerr);
      send_seq(q, 0);
      check("tbl_ok_now", 32'(o_frame_ok), 32'(tbl[v].ok));
      check("tbl_err_now", 32'(o_frame_err), 32'(tbl[v].err));
      check("tbl_busy_now", 32'(o_busy), 32'(tbl[v].ok));
      repeat (3) @(negedge clk);
      check("tbl_ok_pulses", ok_seen - ok0, 32'(tbl[v].ok));
      check("tbl_err_pulses", err_seen - er0, 32'(tbl[v].err));
      check("tbl_err_cnt", 32'(o_err_cnt), 32'(tbl[v].cnt));
      check_display();
    end

    // Timeout latency measured from the acceptance of the last byte.
    q = {8'hA5, 8'h02, 8'h8E};
    model(q, eok, eerr);
    send_seq(q, 0);
    k = 0;
    while (!o_frame_err && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", k, 32'd100);
    repeat (3) @(negedge clk);
    check("timeout_cnt", 32'(o_err_cnt), model_cnt);
    check_display();
    q = {8'hA5, 8'h01, 8'hEE, 8'hEF};
    run_frame(q, 0, 3);
    check_display();

    // Two frames back to back with valid held: only the COMMIT cycle stalls.
    ok0 = ok_seen;
    q = {8'hA5, 8'h01, 8'hEE, 8'hEF};
    model(q, eok, eerr);
    foreach (q[i]) send_byte(q[i], w);
    send_byte(8'hA5, w);
    check("commit_stall", w, 32'd1);
    q = {8'hA5, 8'h01, 8'h11, 8'h10};
    model(q, eok, eerr);
    for (int i = 1; i < 4; i++) send_byte(q[i], w);
    repeat (3) @(negedge clk);
    check("b2b_ok_pulses", ok_seen - ok0, 32'd2);
    check_display();

    for (int f = 0; f < 40; f++) begin
      q.delete();
      t = $urandom % 5;
      if (t == 3) repeat ($urandom_range(1, 3)) begin
        x = 8'($urandom_range(0, 255));
        q.push_back(x == 8'hA5 ? 8'h5A : x);
      end
      q.push_back(8'hA5);
      if (t == 2) q.push_back(($urandom % 2) ? 8'h00 : 8'($urandom_range(9, 255)));
      else begin
        L = $urandom_range(1, N);
        q.push_back(8'(L));
        x = 8'(L);
        repeat (L) begin
          q.push_back(8'($urandom_range(0, 255)));
          x ^= q[q.size()-1];
        end
        q.push_back(t == 1 ? x ^ 8'($urandom_range(1, 255)) : x);
        if (t == 4) repeat ($urandom_range(1, L + 1)) void'(q.pop_back());
      end
      settle = (t == 4) ? TMO + 10 : 3;
      run_frame(q, 2, settle);
      if (f % 5 == 4) check_display();
    end

    // Drive the error counter into saturation.
    q = {8'hA5, 8'h00};
    repeat (260) begin
      model(q, eok, eerr);
      send_seq(q, 0);
    end
    repeat (3) @(negedge clk);
    check("sat_cnt", 32'(o_err_cnt), 32'hFF);
    check_display();

    // One-cycle reset in the middle of a payload.
    q = {8'hA5, 8'h03, 8'h11};
    send_seq(q, 0);
    rstn = 1'b0;
    @(negedge clk);
    foreach (model_disp[i]) model_disp[i] = 8'h00;
    model_cnt = 0;
    check("mrst_cnt", 32'(o_err_cnt), 32'd0);
    check("mrst_digit", 32'(o_digit), 32'd1);
    check("mrst_busy", 32'(o_busy), 32'd0);
    check("mrst_tready", 32'(o_tready), 32'd1);
    check("mrst_seg", 32'(o_abcdefgh), 32'd0);
    rstn = 1'b1;
    check_display();
    q = {8'hA5, 8'h02, 8'h12, 8'h34, 8'h24};
    run_frame(q, 1, 3);
    check_display();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
